// File: rtl/tank_pkg.sv
// Shared types and helpers for the tank level monitor.
// Holds the pump FSM states, the level width helper and the thermometer check.
package tank_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILLING = 2'd1,
    FAULT   = 2'd2
  } state_e;

  function automatic int level_width(input int n);
    return $clog2(n + 1);
  endfunction

  // A thermometer code is a run of ones from bit 0, so adding one
  // carries through every set bit and leaves nothing in common.
  function automatic logic is_thermo(input logic [15:0] v);
    logic [16:0] x;
    x = {1'b0, v};
    return ((x & (x + 17'd1)) == 17'd0);
  endfunction

endpackage

// File: rtl/level_debounce.sv
// Single-bit probe debouncer: deb follows raw only after
// DEBOUNCE_CYCLES consecutive mismatching samples.
// Ports: clock, reset (sync, high), raw in, deb out.
module level_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic deb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (raw != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/tank_level_monitor.sv
// Multi-probe tank level monitor: debounce, level, alarms, pump, LEDs.
// Ports: clock, reset, level_sensors in; led_bar, level, pump_on,
// alarm_low, alarm_high, sensor_fault out (all registered).
module tank_level_monitor
  import tank_pkg::*;
#(
  parameter  int NUM_LEVELS      = 4,
  parameter  int DEBOUNCE_CYCLES = 8,
  parameter  int START_LEVEL     = 1,
  parameter  int BLINK_HALF      = 4,
  localparam int LW = level_width(NUM_LEVELS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_LEVELS-1:0] level_sensors,
  output logic [NUM_LEVELS-1:0] led_bar,
  output logic [LW-1:0]         level,
  output logic                  pump_on,
  output logic                  alarm_low,
  output logic                  alarm_high,
  output logic                  sensor_fault
);

  localparam int BW = $clog2(BLINK_HALF) + 1;

  logic [NUM_LEVELS-1:0] deb;

  for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_deb
    level_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock(clock),
      .reset(reset),
      .raw  (level_sensors[g]),
      .deb  (deb[g])
    );
  end

  state_e                state_q, state_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  fault_q, fault_d;
  logic                  alow_q, alow_d;
  logic                  ahigh_q, ahigh_d;
  logic                  pump_q, pump_d;
  logic [NUM_LEVELS-1:0] led_q, led_d;
  logic [BW-1:0]         blink_q, blink_d;
  logic                  off_q, off_d;

  logic          valid;
  logic [LW-1:0] cnt;

  always_comb begin
    valid = is_thermo(16'(deb));
    cnt   = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      cnt = cnt + LW'(deb[i]);
    end

    level_d = valid ? cnt : level_q;
    fault_d = ~valid;
    alow_d  = valid && (cnt == '0);
    ahigh_d = valid && (cnt == LW'(NUM_LEVELS));
    // pump follows the state one edge late
    pump_d  = (state_q == FILLING);

    state_d = state_q;
    if (!valid) begin
      state_d = FAULT;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cnt <= LW'(START_LEVEL)) state_d = FILLING;
        end
        FILLING: begin
          if (cnt == LW'(NUM_LEVELS)) state_d = IDLE;
        end
        FAULT:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // blink phase restarts (LEDs on) on every fault entry
    blink_d = '0;
    off_d   = 1'b0;
    if (state_d == FAULT && state_q == FAULT) begin
      if (blink_q == BW'(BLINK_HALF - 1)) begin
        off_d = ~off_q;
      end else begin
        blink_d = blink_q + BW'(1);
        off_d   = off_q;
      end
    end

    if (state_d == FAULT) begin
      led_d = off_d ? '0 : '1;
    end else begin
      led_d = deb;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      level_q <= '0;
      fault_q <= 1'b0;
      alow_q  <= 1'b0;
      ahigh_q <= 1'b0;
      pump_q  <= 1'b0;
      led_q   <= '0;
      blink_q <= '0;
      off_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      fault_q <= fault_d;
      alow_q  <= alow_d;
      ahigh_q <= ahigh_d;
      pump_q  <= pump_d;
      led_q   <= led_d;
      blink_q <= blink_d;
      off_q   <= off_d;
    end
  end

  assign led_bar      = led_q;
  assign level        = level_q;
  assign pump_on      = pump_q;
  assign alarm_low    = alow_q;
  assign alarm_high   = ahigh_q;
  assign sensor_fault = fault_q;

endmodule

// File: tb/tb_tank_level_monitor.sv
// Testbench for tank_level_monitor: directed scenarios plus random
// probe patterns, checked every cycle against a behavioural model.
module tb_tank_level_monitor;

  localparam int NL = 4;
  localparam int D  = 8;
  localparam int SL = 1;
  localparam int BH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NL-1:0] level_sensors = '0;
  logic [NL-1:0] led_bar;
  logic [2:0]    level;
  logic          pump_on;
  logic          alarm_low;
  logic          alarm_high;
  logic          sensor_fault;

  always #5 clock = ~clock;

  tank_level_monitor #(
    .NUM_LEVELS     (NL),
    .DEBOUNCE_CYCLES(D),
    .START_LEVEL    (SL),
    .BLINK_HALF     (BH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .level_sensors(level_sensors),
    .led_bar      (led_bar),
    .level        (level),
    .pump_on      (pump_on),
    .alarm_low    (alarm_low),
    .alarm_high   (alarm_high),
    .sensor_fault (sensor_fault)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clock);
  endtask

  // ---------------- behavioural model ----------------
  logic [NL-1:0] hist [64];
  int            n = 0;
  int            last_tog [NL];
  logic [NL-1:0] m_deb = '0;
  logic [2:0]    m_level = '0;
  logic          m_fault = 1'b0;
  logic          m_alow = 1'b0;
  logic          m_ahigh = 1'b0;
  logic          m_pump = 1'b0;
  logic [NL-1:0] m_led = '0;
  int            m_state = 0;   // 0 idle, 1 filling, 2 fault
  int            m_ft = 0;      // edges spent in fault so far
  bit            m_on = 1'b0;

  function automatic bit thermo(input logic [NL-1:0] v);
    for (int k = 0; k <= NL; k++) begin
      if (v == NL'((1 << k) - 1)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [NL-1:0] old;
    logic [5:0]    idx;
    bit            v;
    bit            ok;
    int            ns;
    n++;
    if (reset) begin
      m_deb   = '0;
      m_level = '0;
      m_fault = 1'b0;
      m_alow  = 1'b0;
      m_ahigh = 1'b0;
      m_pump  = 1'b0;
      m_led   = '0;
      m_state = 0;
      m_ft    = 0;
      for (int i = 0; i < NL; i++) last_tog[i] = n;
      m_on = 1'b1;
    end else begin
      old = m_deb;
      v   = thermo(old);
      if (v) m_level = 3'($countones(old));
      m_fault = !v;
      m_alow  = v && (old == '0);
      m_ahigh = v && (old == '1);
      m_pump  = (m_state == 1);
      if (!v) ns = 2;
      else if (m_state == 2) ns = 0;
      else if (m_state == 0 && int'(m_level) <= SL) ns = 1;
      else if (m_state == 1 && int'(m_level) == NL) ns = 0;
      else ns = m_state;
      if (ns == 2) begin
        m_ft  = (m_state == 2) ? m_ft + 1 : 0;
        m_led = ((m_ft / BH) % 2 == 0) ? '1 : '0;
      end else begin
        m_led = old;
      end
      m_state = ns;
      // a bit flips when the last D samples since its previous
      // flip (or reset) all disagreed with it
      idx = 6'(n % 64);
      hist[idx] = level_sensors;
      for (int i = 0; i < NL; i++) begin
        ok = (n - last_tog[i] >= D);
        if (ok) begin
          for (int j = 0; j < D; j++) begin
            idx = 6'((n - j) % 64);
            if (hist[idx][i] == old[i]) ok = 1'b0;
          end
        end
        if (ok) begin
          m_deb[i]    = ~old[i];
          last_tog[i] = n;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (m_on) begin
      check("model_outputs",
            32'({led_bar, level, pump_on, alarm_low,
                 alarm_high, sensor_fault}),
            32'({m_led, m_level, m_pump, m_alow,
                 m_ahigh, m_fault}));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [NL-1:0] pat;
    int            hold;

    // 1. reset with wet probes, then release
    reset = 1'b1;
    level_sensors = 4'b1111;
    step(3);
    check("rst_outputs",
          32'({led_bar, level, pump_on, alarm_low,
               alarm_high, sensor_fault}), 32'd0);
    reset = 1'b0;
    step(1);
    check("pump_e1", 32'(pump_on), 32'd0);
    step(1);
    check("pump_e2", 32'(pump_on), 32'd1);
    check("alow_e2", 32'(alarm_low), 32'd1);
    step(6);
    check("level_e8", 32'(level), 32'd0);
    step(1);
    check("level_e9", 32'(level), 32'd4);
    check("ahigh_e9", 32'(alarm_high), 32'd1);
    check("pump_e9", 32'(pump_on), 32'd1);
    step(1);
    check("pump_e10", 32'(pump_on), 32'd0);

    // 2. glitch rejection
    level_sensors = 4'b0011;
    step(20);
    check("glitch_base", 32'(level), 32'd2);
    level_sensors = 4'b0111;
    step(7);
    level_sensors = 4'b0011;
    step(20);
    check("glitch7", 32'(level), 32'd2);
    level_sensors = 4'b0111;
    step(8);
    check("glitch8_e8", 32'(level), 32'd2);
    level_sensors = 4'b0011;
    step(1);
    check("glitch8_e9", 32'(level), 32'd3);
    step(20);

    // 3. hysteresis
    level_sensors = 4'b0000; step(20);
    check("hyst_0", 32'(pump_on), 32'd1);
    level_sensors = 4'b0001; step(20);
    check("hyst_1", 32'(pump_on), 32'd1);
    level_sensors = 4'b0011; step(20);
    check("hyst_2", 32'(pump_on), 32'd1);
    level_sensors = 4'b0111; step(20);
    check("hyst_3", 32'(pump_on), 32'd1);
    level_sensors = 4'b1111; step(20);
    check("hyst_4", 32'(pump_on), 32'd0);
    check("hyst_4_lvl", 32'(level), 32'd4);
    level_sensors = 4'b0011; step(20);
    check("drain_2", 32'(pump_on), 32'd0);
    check("drain_2_lvl", 32'(level), 32'd2);
    level_sensors = 4'b0001;
    for (int i = 0; i < 40 && level != 3'd1; i++) step(1);
    check("drain_1_lvl", 32'(level), 32'd1);
    check("drain_1_pump0", 32'(pump_on), 32'd0);
    step(1);
    check("drain_1_pump1", 32'(pump_on), 32'd1);

    // 4. fault
    level_sensors = 4'b0101;
    for (int i = 0; i < 40 && !sensor_fault; i++) step(1);
    check("fault_set", 32'(sensor_fault), 32'd1);
    check("fault_lvl", 32'(level), 32'd1);
    check("fault_alarms", 32'({alarm_low, alarm_high}), 32'd0);
    check("blink_e0", 32'(led_bar), 32'hF);
    step(3);
    check("blink_e3", 32'(led_bar), 32'hF);
    check("fault_pump", 32'(pump_on), 32'd0);
    step(1);
    check("blink_e4", 32'(led_bar), 32'h0);
    step(3);
    check("blink_e7", 32'(led_bar), 32'h0);
    step(1);
    check("blink_e8", 32'(led_bar), 32'hF);
    step(8);
    level_sensors = 4'b0111;
    for (int i = 0; i < 40 && sensor_fault; i++) step(1);
    check("fault_clr", 32'(sensor_fault), 32'd0);
    check("fault_clr_lvl", 32'(level), 32'd3);
    check("fault_clr_led", 32'(led_bar), 32'h7);
    step(2);
    check("fault_clr_idle", 32'(pump_on), 32'd0);

    // 5. reset mid-filling
    level_sensors = 4'b0001; step(20);
    level_sensors = 4'b0011; step(20);
    check("mid_pump", 32'(pump_on), 32'd1);
    check("mid_lvl", 32'(level), 32'd2);
    reset = 1'b1;
    step(1);
    check("mid_rst",
          32'({led_bar, level, pump_on, alarm_low,
               alarm_high, sensor_fault}), 32'd0);
    reset = 1'b0;
    step(8);
    check("mid_e8", 32'(level), 32'd0);
    step(1);
    check("mid_e9", 32'(level), 32'd2);

    // random phase
    for (int r = 0; r < 150; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        pat = NL'($urandom_range(0, 15));
      end else begin
        pat = NL'((1 << $urandom_range(0, NL)) - 1);
      end
      level_sensors = pat;
      hold = int'($urandom_range(1, 25));
      step(hold);
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end
    end
    step(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tank_level_monitor.md
Name: tank_level_monitor

Overview:
Parametrised multi-probe tank level monitor. Debounces a column of NUM_LEVELS level probes, converts the thermometer pattern to a binary level, and drives an LED bar graph, low and high alarms, and a hysteretic pump-fill controller. Inconsistent probe patterns are flagged as a sensor fault, and the LED bar blinks while the fault persists. The block sits between the synchronised probe inputs and the front-panel LED and pump driver logic.

Parameters:
NUM_LEVELS, 4, number of probes; bit 0 is the lowest probe; legal range 2..16
DEBOUNCE_CYCLES, 8, consecutive mismatching samples required before a debounced probe bit changes; >=1
START_LEVEL, 1, pump starts when level <= START_LEVEL; must be < NUM_LEVELS
BLINK_HALF, 4, LED blink half-period in clock cycles during fault; >=1

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
level_sensors  input  NUM_LEVELS  raw probe states, 1 = wet; already synchronous to clock
led_bar  output  NUM_LEVELS  bar-graph LEDs
level  output  LW = clog2(NUM_LEVELS+1)  count of wet probes (last valid value)
pump_on  output  1  fill pump enable
alarm_low  output  1  level == 0 and no fault
alarm_high  output  1  level == NUM_LEVELS and no fault
sensor_fault  output  1  debounced pattern is not a thermometer code

Behaviour:
- Reset (clock edge with reset=1):
  - debounced bits deb = 0; debounce counters = 0; blink counter = 0; state = IDLE.
  - All outputs = 0, including level = 0.
  - Reset asserted mid-operation overrides everything on that edge and returns to these values.
- Debounce, per bit i:
  - On an edge where raw[i] == deb[i]: counter clears.
  - On an edge where raw[i] != deb[i]: counter increments.
  - On the DEBOUNCE_CYCLES-th consecutive mismatching edge: deb[i] toggles and the counter clears.
  - A single agreeing sample restarts the count.
- Validity:
  - deb is valid iff it equals (1<<k)-1 for some k in 0..NUM_LEVELS.
  - 0 is valid; all-ones is valid.
- Output registers, updated one edge after deb changes:
  - Total raw-to-output latency is DEBOUNCE_CYCLES+1 edges.
  - If deb is valid: level = popcount(deb), sensor_fault = 0.
  - If deb is invalid: level holds its last value, sensor_fault = 1.
  - alarm_low and alarm_high are forced to 0 while sensor_fault = 1.
- Pump FSM states: IDLE, FILLING, FAULT. Transitions are evaluated on the new deb validity and level; fault has priority over all other transitions.
  - IDLE -> FAULT if deb invalid; else IDLE -> FILLING if level <= START_LEVEL.
  - FILLING -> FAULT if deb invalid; else FILLING -> IDLE if level == NUM_LEVELS.
  - Levels between START_LEVEL and NUM_LEVELS keep the current state (hysteresis).
  - FAULT -> IDLE when deb becomes valid. Re-entering FILLING takes the normal IDLE rule on the following edge.
  - pump_on = 1 only in FILLING (registered).
- LED bar:
  - In IDLE and FILLING: led_bar = deb (registered).
  - In FAULT: the blink counter clears on entry. led_bar = all-ones for BLINK_HALF cycles, then all-zeros for BLINK_HALF cycles, repeating.
- After reset release with dry probes: level = 0, so the FSM enters FILLING on the first edge and pump_on = 1 on the second edge.
- Widths: the popcount result is LW bits wide with no overflow. The blink counter is clog2(BLINK_HALF)+1 bits and wraps at BLINK_HALF-1.

Decomposition:
- Package tank_pkg holds:
  - state enum: IDLE = 2'd0, FILLING = 2'd1, FAULT = 2'd2.
  - a clog2-based width helper for LW.
  - a function checking thermometer validity.
- Sub-module level_debounce: single-bit debouncer with DEBOUNCE_CYCLES parameter, ports clock/reset/raw/deb. It is instantiated NUM_LEVELS times through a generate loop.
- FSM, popcount and blink logic stay in the top module.

Test Plan:
Defaults for all scenarios: NUM_LEVELS=4, DEBOUNCE_CYCLES=8, START_LEVEL=1, BLINK_HALF=4.
1. Reset: hold reset 3 cycles with sensors=4'b1111 -> all outputs 0 during reset. After release: pump_on=1 at edge 2; level=4, alarm_high=1 at edge 9; pump_on=0 at edge 10.
2. Glitch rejection: sensors stable at 0011 with level=2. Pulse bit2 high for 7 cycles -> level stays 2. Pulse for 8 cycles -> level=3 exactly 9 edges after the rising sample.
3. Hysteresis: ramp 0000 -> 0001 -> 0011 -> 0111 -> 1111 (each held 20 cycles) -> pump_on stays 1 until level=4, then 0. Drain to 0011 -> pump stays 0. Drain to 0001 -> pump_on=1 one edge after level=1.
4. Fault: apply 0101 for 20 cycles -> sensor_fault=1, pump_on=0, level holds 1, alarms 0, led_bar alternates 1111/0000 every 4 cycles. Then apply 0111 -> sensor_fault=0, level=3, state IDLE, led_bar=0111.
5. Reset mid-FILLING: assert reset for 1 cycle while pump_on=1 and level=2 -> all outputs 0 on that edge and counters cleared. Debounced level reappears DEBOUNCE_CYCLES+1 edges later.
